// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// Purpose : UART receiver. Samples an asynchronous RX line at mid-bit, places
//           each payload bit at its own position of the output word (LSB
//           first), checks start/stop framing and emits a one-cycle strobe
//           for every good frame (data_valid) or bad stop bit (frame_err).
// Ports   :
//   i_clk          system clock, all logic on rising edge
//   i_rst_n        synchronous reset, active low
//   i_rx           asynchronous serial input, idle high
//   o_data_out     last good word received, bit 0 = first data bit
//   o_data_valid   1-cycle pulse, o_data_out just updated with a good frame
//   o_frame_err    1-cycle pulse, stop bit sampled low (o_data_out unchanged)
//   o_busy         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_data_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_frame_err;
    logic                   r_busy;
    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic                   w_rx_fall;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // A held-low line never produces a new edge, so a break yields one frame only.
    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // Frame FSM: counters, bit placement and registered strobes/outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_bit_idx    <= {IDX_W{1'b0}};
            r_shift      <= {DATA_BITS{1'b0}};
            r_data_out   <= {DATA_BITS{1'b0}};
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (w_rx_fall) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (!r_rx_sync) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= {IDX_W{1'b0}};
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= {CNT_W{1'b0}};
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_bit_idx == IDX_W'(i)) begin
                                r_shift[i] <= r_rx_sync;
                            end
                        end
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (r_rx_sync) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = r_busy;

endmodule
